npxl_frame_ctrl: RTL and testbench
==================================

Name: npxl_frame_ctrl

Overview:
Frame scheduler and colour source for the NeoPixel driver in the VU meter. It takes audio level samples, computes a bar graph with a decaying peak marker, and writes it into a double-buffered LED colour store. It starts one driver transfer per frame via the driver's i_en/o_rdy handshake. It also serves the driver's colour fetches by address.

Parameters:
LEDS, 20, number of LEDs in the chain.
ADDR, 8, width of the colour address bus; must satisfy 2^ADDR > LEDS.
FRAME_CYCLES, 800000, i_clk cycles per frame tick (60 Hz at 48 MHz).
DECAY_FRAMES, 4, frames per one-LED peak decay step; minimum 1.
LOW_LEDS, 12, bar LEDs [0, LOW_LEDS) use COL_LOW.
MID_LEDS, 5, bar LEDs [LOW_LEDS, LOW_LEDS+MID_LEDS) use COL_MID; higher LEDs use COL_HIGH.
COL_LOW, 24'h100000, GRB colour for the low segment.
COL_MID, 24'h101000, GRB colour for the mid segment.
COL_HIGH, 24'h001000, GRB colour for the high segment.
COL_PEAK, 24'h101010, GRB colour for the peak marker.

Ports:
i_clk  in  1  system clock, 48 MHz.
i_rst_n  in  1  asynchronous active-low reset.
i_level  in  8  unsigned audio level sample.
i_level_vld  in  1  i_level is valid this cycle.
i_npxl_rdy  in  1  driver ready (driver o_rdy).
i_color_addr  in  ADDR  LED index requested by the driver (driver o_color_reg).
o_color_data  out  24  GRB colour of front buffer[i_color_addr] (driver i_color_data).
o_npxl_en  out  1  one-cycle transfer start pulse (driver i_en).
o_frame_done  out  1  one-cycle pulse when the driver returns to ready after a frame.
o_overrun  out  1  one-cycle pulse when a frame tick is dropped.
o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is asynchronous and active-low; one clock, i_clk.
- Reset values:
  - All outputs 0 and both buffers cleared to 0.
  - State IDLE.
  - Tick counter, level accumulator, lit, peak and decay counter all 0.
  - Front buffer select = 0.
- Tick counter:
  - Free-running from 0 to FRAME_CYCLES-1, then wraps to 0.
  - tick = 1 on the cycle the counter equals FRAME_CYCLES-1.
  - The counter never pauses.
- Level accumulator:
  - On i_level_vld, acc <= max(acc, i_level).
  - In SNAP the accumulator is cleared. If i_level_vld is high in that same cycle, acc <= i_level, so the sample is not lost.
- o_color_data:
  - Combinational read of the front buffer at i_color_addr.
  - Returns 0 when i_color_addr >= LEDS.
  - Combinational because the driver samples it on the cycle after it changes the address.
- FSM:
  - IDLE: on tick go to SNAP.
  - SNAP, 1 cycle:
    - lit = (acc*LEDS + 255) >> 8, computed with width ADDR+9 bits.
    - If lit >= peak: peak <= lit and decay counter <= 0.
    - Else if decay counter == DECAY_FRAMES-1: peak <= peak-1 and decay counter <= 0.
    - Else: decay counter increments.
  - BUILD, LEDS cycles, idx 0..LEDS-1: write back buffer[idx] per the rule below, one write per cycle.
    - If peak > 0 and idx == peak-1: COL_PEAK.
    - Else if idx < lit: COL_LOW, COL_MID or COL_HIGH by segment.
    - Else: 0.
  - WAIT_RDY: stay until i_npxl_rdy = 1.
  - KICK, 1 cycle: o_npxl_en = 1; toggle the front buffer select on the same edge.
  - DRAIN: wait for i_npxl_rdy = 0, then for i_npxl_rdy = 1. Then o_frame_done = 1 for one cycle and go to IDLE.
- Latency:
  - SNAP is the cycle after tick.
  - o_npxl_en rises LEDS+3 cycles after the tick cycle when the driver is already ready.
- Overrun:
  - Applies to a tick while the state is not IDLE.
  - The tick is ignored and o_overrun pulses for 1 cycle.
  - The frame in progress completes normally.
- Buffer ownership:
  - The driver reads only the front buffer; BUILD writes only the back buffer.
  - The front buffer never changes during a transfer.
- Reset mid-transfer: all state returns to reset values immediately and o_npxl_en is forced to 0. A driver that is mid-transfer reads zeros and completes.

Test Plan:
1. Reset: hold i_rst_n = 0 for 5 cycles, release -> all outputs 0 and o_color_data = 0 for every address. First o_npxl_en occurs at tick + LEDS+3.
2. Full scale with LEDS=8, FRAME_CYCLES=100, LOW_LEDS=4, MID_LEDS=2: i_level = 255 for one sample -> lit = 8, peak = 8. Front buffer after KICK:
   - LEDs 0-3 = COL_LOW.
   - LEDs 4-5 = COL_MID.
   - LED 6 = COL_HIGH.
   - LED 7 = COL_PEAK.
3. Peak decay with DECAY_FRAMES=2: level 255, then 0 for all later frames -> peak 8,8,7,7,6, …, reaching 0 after 16 frames; lit = 0 throughout.
4. Max hold: samples 40, 200, 10 within one frame -> lit = (200*8+255)>>8 = 7. A sample arriving in the SNAP cycle becomes the next frame's accumulator start.
5. Driver stall: hold i_npxl_rdy = 0 across two ticks -> one o_overrun pulse; o_npxl_en only after rdy = 1; exactly one o_frame_done per completed transfer.
6. Address bounds: drive i_color_addr = LEDS and 2^ADDR-1 -> o_color_data = 0.

Source files
------------

// File: rtl/npxl_frame_ctrl_if.sv
// Handshake and colour-fetch bus between the VU-meter frame controller and its
// environment (audio level source and NeoPixel driver).
interface npxl_frame_ctrl_if #(
    parameter int ADDR = 8
);
    logic [7:0]      i_level;
    logic            i_level_vld;
    logic            i_npxl_rdy;
    logic [ADDR-1:0] i_color_addr;
    logic [23:0]     o_color_data;
    logic            o_npxl_en;
    logic            o_frame_done;
    logic            o_overrun;
    logic            o_busy;

    modport master (
        output i_level, i_level_vld, i_npxl_rdy, i_color_addr,
        input  o_color_data, o_npxl_en, o_frame_done, o_overrun, o_busy
    );

    modport slave (
        input  i_level, i_level_vld, i_npxl_rdy, i_color_addr,
        output o_color_data, o_npxl_en, o_frame_done, o_overrun, o_busy
    );
endinterface

// File: rtl/npxl_frame_ctrl.sv
// VU-meter frame scheduler: turns audio levels into a bar graph with a decaying
// peak marker in a double-buffered colour store and kicks one driver transfer per frame.
module npxl_frame_ctrl #(
    parameter int          LEDS         = 20,
    parameter int          ADDR         = 8,
    parameter int          FRAME_CYCLES = 800000,
    parameter int          DECAY_FRAMES = 4,
    parameter int          LOW_LEDS     = 12,
    parameter int          MID_LEDS     = 5,
    parameter logic [23:0] COL_LOW      = 24'h100000,
    parameter logic [23:0] COL_MID      = 24'h101000,
    parameter logic [23:0] COL_HIGH     = 24'h001000,
    parameter logic [23:0] COL_PEAK     = 24'h101010
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    npxl_frame_ctrl_if.slave   bus
);

    localparam int IW = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int LW = ADDR + 1;
    localparam int PW = ADDR + 9;
    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        BUILD,
        WAIT_RDY,
        KICK,
        DRAIN_LO,
        DRAIN_HI
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]      acc_q, acc_d;
    logic [LW-1:0]   lit_q, lit_d;
    logic [LW-1:0]   peak_q, peak_d;
    logic [DW-1:0]   decay_q, decay_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            front_q, front_d;
    logic            en_q, en_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;

    logic [23:0]     buf0_q [LEDS];
    logic [23:0]     buf1_q [LEDS];

    logic            tick;
    logic            wr_en;
    logic [23:0]     wr_data;
    logic [PW-1:0]   prod;
    logic [LW-1:0]   lit_calc;
    logic [IW-1:0]   rd_idx;

    function automatic logic [23:0] bar_colour(input logic [LW-1:0] idx,
                                               input logic [LW-1:0] lit,
                                               input logic [LW-1:0] peak);
        logic [23:0] col;
        col = '0;
        if (peak != '0 && idx == peak - LW'(1)) begin
            col = COL_PEAK;
        end else if (idx < lit) begin
            if (idx < LW'(LOW_LEDS)) begin
                col = COL_LOW;
            end else if (idx < LW'(LOW_LEDS + MID_LEDS)) begin
                col = COL_MID;
            end else begin
                col = COL_HIGH;
            end
        end
        return col;
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TW'(FRAME_CYCLES - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        prod       = PW'(acc_q) * PW'(LEDS) + PW'(255);
        lit_calc   = LW'(prod >> 8);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lit_d   = lit_q;
        peak_d  = peak_q;
        decay_d = decay_q;
        idx_d   = idx_q;
        front_d = front_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        ovr_d   = tick && (state_q != IDLE);
        wr_en   = 1'b0;
        wr_data = '0;

        // A sample landing in SNAP seeds the next frame rather than being dropped.
        if (state_q == SNAP) begin
            acc_d = bus.i_level_vld ? bus.i_level : 8'd0;
        end else if (bus.i_level_vld && bus.i_level > acc_q) begin
            acc_d = bus.i_level;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                lit_d = lit_calc;
                if (lit_calc >= peak_q) begin
                    peak_d  = lit_calc;
                    decay_d = '0;
                end else if (decay_q == DW'(DECAY_FRAMES - 1)) begin
                    peak_d  = peak_q - LW'(1);
                    decay_d = '0;
                end else begin
                    decay_d = decay_q + DW'(1);
                end
                idx_d   = '0;
                state_d = BUILD;
            end
            BUILD: begin
                wr_en   = 1'b1;
                wr_data = bar_colour(LW'(idx_q), lit_q, peak_q);
                if (idx_q == IW'(LEDS - 1)) begin
                    state_d = WAIT_RDY;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            WAIT_RDY: begin
                // Swap buffers on the same edge that raises the start pulse.
                if (bus.i_npxl_rdy) begin
                    state_d = KICK;
                    en_d    = 1'b1;
                    front_d = ~front_q;
                end
            end
            KICK: begin
                state_d = DRAIN_LO;
            end
            DRAIN_LO: begin
                if (!bus.i_npxl_rdy) begin
                    state_d = DRAIN_HI;
                end
            end
            DRAIN_HI: begin
                if (bus.i_npxl_rdy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            acc_q      <= '0;
            lit_q      <= '0;
            peak_q     <= '0;
            decay_q    <= '0;
            idx_q      <= '0;
            front_q    <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            acc_q      <= acc_d;
            lit_q      <= lit_d;
            peak_q     <= peak_d;
            decay_q    <= decay_d;
            idx_q      <= idx_d;
            front_q    <= front_d;
            en_q       <= en_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    // BUILD only ever writes the buffer the driver is not reading.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LEDS; i++) begin
                buf0_q[i] <= '0;
                buf1_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (front_q) begin
                buf0_q[idx_q] <= wr_data;
            end else begin
                buf1_q[idx_q] <= wr_data;
            end
        end
    end

    // Combinational fetch: the driver samples data the cycle after it moves the address.
    always_comb begin
        rd_idx           = bus.i_color_addr[IW-1:0];
        bus.o_color_data = '0;
        if (bus.i_color_addr < ADDR'(LEDS)) begin
            bus.o_color_data = front_q ? buf1_q[rd_idx] : buf0_q[rd_idx];
        end
    end

    assign bus.o_npxl_en    = en_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_overrun    = ovr_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_npxl_frame_ctrl.sv
// Scoreboard bench for npxl_frame_ctrl: expected front-buffer frames are queued as
// levels are driven and compared when the controller starts a transfer.
module tb_npxl_frame_ctrl;

    localparam int          LEDS         = 8;
    localparam int          ADDR         = 8;
    localparam int          FRAME_CYCLES = 100;
    localparam int          DECAY_FRAMES = 2;
    localparam int          LOW_LEDS     = 4;
    localparam int          MID_LEDS     = 2;
    localparam logic [23:0] COL_LOW      = 24'h100000;
    localparam logic [23:0] COL_MID      = 24'h101000;
    localparam logic [23:0] COL_HIGH     = 24'h001000;
    localparam logic [23:0] COL_PEAK     = 24'h101010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    npxl_frame_ctrl_if #(.ADDR(ADDR)) bus ();

    npxl_frame_ctrl #(
        .LEDS(LEDS), .ADDR(ADDR), .FRAME_CYCLES(FRAME_CYCLES),
        .DECAY_FRAMES(DECAY_FRAMES), .LOW_LEDS(LOW_LEDS), .MID_LEDS(MID_LEDS),
        .COL_LOW(COL_LOW), .COL_MID(COL_MID), .COL_HIGH(COL_HIGH), .COL_PEAK(COL_PEAK)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int en_cnt   = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;

    int m_peak  = 0;
    int m_dc    = 0;
    int m_carry = 0;
    logic [LEDS*24-1:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus.o_npxl_en)    en_cnt++;
        if (bus.o_frame_done) done_cnt++;
        if (bus.o_overrun)    ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_colour(input int i, input int lit, input int peak);
        if (peak > 0 && i == peak - 1) return COL_PEAK;
        if (i < lit) begin
            if (i < LOW_LEDS)            return COL_LOW;
            if (i < LOW_LEDS + MID_LEDS) return COL_MID;
            return COL_HIGH;
        end
        return 24'h0;
    endfunction

    task automatic run_frame(input int ns, input int s0, input int s1, input int s2,
                             input bit snap_en, input int snap_lvl,
                             input bit stall, input bit first, input bit mid_rst);
        int acc, lit, e0, d0, o0;
        int smp [3];
        logic [LEDS*24-1:0] fr, ex;
        smp[0] = s0; smp[1] = s1; smp[2] = s2;
        acc = m_carry;
        m_carry = 0;
        if (stall) bus.i_npxl_rdy = 1'b0;
        for (int i = 0; i < ns; i++) begin
            @(negedge clk);
            bus.i_level     = 8'(smp[i]);
            bus.i_level_vld = 1'b1;
            @(negedge clk);
            bus.i_level_vld = 1'b0;
            if (smp[i] > acc) acc = smp[i];
        end
        lit = (acc * LEDS + 255) >> 8;
        if (lit >= m_peak) begin
            m_peak = lit; m_dc = 0;
        end else if (m_dc == DECAY_FRAMES - 1) begin
            m_peak = m_peak - 1; m_dc = 0;
        end else begin
            m_dc = m_dc + 1;
        end
        for (int i = 0; i < LEDS; i++) fr[i*24 +: 24] = exp_colour(i, lit, m_peak);
        exp_q.push_back(fr);

        for (int k = 0; k < 2 * FRAME_CYCLES && !bus.o_busy; k++) @(negedge clk);
        check("busy_snap", {31'd0, bus.o_busy}, 32'd1);
        if (snap_en) begin
            bus.i_level     = 8'(snap_lvl);
            bus.i_level_vld = 1'b1;
            @(negedge clk);
            bus.i_level_vld = 1'b0;
            m_carry = snap_lvl;
        end
        e0 = en_cnt; d0 = done_cnt; o0 = ovr_cnt;
        if (stall) begin
            repeat (150) @(negedge clk);
            check("stall_overrun", ovr_cnt - o0, 32'd1);
            check("stall_no_en", en_cnt - e0, 32'd0);
            bus.i_npxl_rdy = 1'b1;
        end

        for (int k = 0; k < 3 * FRAME_CYCLES && !bus.o_npxl_en; k++) @(negedge clk);
        check("en_seen", {31'd0, bus.o_npxl_en}, 32'd1);
        if (first) check("en_latency", cyc, FRAME_CYCLES - 1 + LEDS + 3);
        bus.i_npxl_rdy = 1'b0;
        ex = exp_q.pop_front();

        if (mid_rst) begin
            bus.i_color_addr = '0;
            #1;
            check("pre_rst_col", {8'd0, bus.o_color_data}, {8'd0, ex[23:0]});
            rst_n = 1'b0;
            #1;
            check("rst_col", {8'd0, bus.o_color_data}, 32'd0);
            check("rst_en", {31'd0, bus.o_npxl_en}, 32'd0);
            check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
            return;
        end

        for (int i = 0; i < LEDS; i++) begin
            bus.i_color_addr = ADDR'(i);
            #1;
            check($sformatf("led%0d", i), {8'd0, bus.o_color_data}, {8'd0, ex[i*24 +: 24]});
            @(negedge clk);
        end
        bus.i_color_addr = ADDR'(LEDS);
        #1;
        check("oob_leds", {8'd0, bus.o_color_data}, 32'd0);
        bus.i_color_addr = '1;
        #1;
        check("oob_max", {8'd0, bus.o_color_data}, 32'd0);
        bus.i_npxl_rdy = 1'b1;

        for (int k = 0; k < 50 && !bus.o_frame_done; k++) @(negedge clk);
        check("done_seen", {31'd0, bus.o_frame_done}, 32'd1);
        @(negedge clk);
        check("done_once", done_cnt - d0, 32'd1);
        check("en_once", en_cnt - e0, 32'd1);
    endtask

    initial begin
        bus.i_level      = '0;
        bus.i_level_vld  = 1'b0;
        bus.i_npxl_rdy   = 1'b1;
        bus.i_color_addr = '0;
        rst_n            = 1'b0;
        repeat (5) @(negedge clk);
        for (int a = 0; a < LEDS + 2; a++) begin
            bus.i_color_addr = ADDR'(a);
            #1;
            check("rst_buf", {8'd0, bus.o_color_data}, 32'd0);
        end
        bus.i_color_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_en", {31'd0, bus.o_npxl_en}, 32'd0);
        check("rst_done", {31'd0, bus.o_frame_done}, 32'd0);
        check("rst_ovr", {31'd0, bus.o_overrun}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);

        // Full scale: bar of 8 with the top LED as the peak marker.
        run_frame(1, 255, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        // Silence: peak decays one LED every two frames down to zero.
        for (int f = 0; f < 17; f++) run_frame(0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // Max hold within a frame, plus a sample arriving during SNAP.
        run_frame(3, 40, 200, 10, 1'b1, 100, 1'b0, 1'b0, 1'b0);
        run_frame(0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // Driver stalled across a tick.
        run_frame(1, 128, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        // Reset during a transfer.
        run_frame(1, 255, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
